// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - state_e       : controller state (RUN / DRAIN)
//   - STG_*         : index of each pipeline control bit
//   - SRC_*         : index of each hazard request source
//   - DEF_*_MASK    : default per-source stall / flush tables (source i at slice i)
//   - mask_slice()  : extracts one source's stage vector from a packed table
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam int STG_PC     = 0;
    localparam int STG_PRE_IF = 1;
    localparam int STG_IF_ID  = 2;
    localparam int STG_ID_EX  = 3;
    localparam int STG_EX_MEM = 4;
    localparam int STG_MEM_WB = 5;

    localparam int SRC_LOAD_USE   = 0;
    localparam int SRC_MULDIV     = 1;
    localparam int SRC_JUMP       = 2;
    localparam int SRC_RAM_IF     = 3;
    localparam int SRC_TRAP_CSR   = 4;
    localparam int SRC_TRAP_ECALL = 5;
    localparam int SRC_RAM_MEM    = 6;

    localparam int DEF_STAGES  = 6;
    localparam int DEF_NUM_REQ = 8;

    // Largest table / stage vector the slice helper can handle.
    localparam int MASK_MAX_W  = 512;
    localparam int STAGE_MAX_W = 32;

    // Source 7 is a spare slot with no effect.
    localparam logic [DEF_NUM_REQ*DEF_STAGES-1:0] DEF_STALL_MASK = {
        6'b000000,   // 7 spare
        6'b011111,   // 6 ram-mem   : hold everything up to EX_MEM
        6'b000000,   // 5 trap-ecall
        6'b000000,   // 4 trap-csr
        6'b000011,   // 3 ram-if    : hold PC and Pre_IF
        6'b000000,   // 2 jump
        6'b001111,   // 1 mul/div   : hold up to ID_EX
        6'b000111    // 0 load-use  : hold PC, Pre_IF, IF_ID
    };

    localparam logic [DEF_NUM_REQ*DEF_STAGES-1:0] DEF_FLUSH_MASK = {
        6'b000000,   // 7 spare
        6'b100000,   // 6 ram-mem   : bubble into MEM_WB
        6'b011110,   // 5 trap-ecall: kill everything younger than WB
        6'b001110,   // 4 trap-csr  : kill up to ID_EX
        6'b000100,   // 3 ram-if    : bubble into IF_ID
        6'b000110,   // 2 jump      : kill the wrong-path fetches
        6'b010000,   // 1 mul/div   : bubble into EX_MEM
        6'b001000    // 0 load-use  : bubble into ID_EX
    };

    // Returns the stage vector of source idx from a table of stages-wide slices.
    function automatic logic [STAGE_MAX_W-1:0] mask_slice(
        input logic [MASK_MAX_W-1:0] mask,
        input int unsigned           idx,
        input int unsigned           stages
    );
        logic [STAGE_MAX_W-1:0] keep;
        keep = {STAGE_MAX_W{1'b1}} >> (STAGE_MAX_W - stages);
        return STAGE_MAX_W'(mask >> (idx * stages)) & keep;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundles the hazard controller's request, fetch-tracking and status signals.
//   req_valid_i    : per-source hazard request (level)
//   if_req_fire_i  : fetch request accepted this cycle
//   if_rsp_valid_i : fetch response returned this cycle
//   stall_o/flush_o: per-stage pipeline control
//   if_rsp_drop_o  : current response is stale and must be discarded
//   stall_cycles_o : saturating count of PC-stall cycles
//   timeout_o      : sticky watchdog flag
//   err_o          : sticky fetch-protocol error flag
// master = pipeline side driving requests, slave = the controller.
interface pipe_hazard_ctrl_if #(
    parameter int NUM_REQ = 8,
    parameter int STAGES  = 6,
    parameter int CNT_W   = 32
);
    logic [NUM_REQ-1:0] req_valid_i;
    logic               if_req_fire_i;
    logic               if_rsp_valid_i;
    logic [STAGES-1:0]  stall_o;
    logic [STAGES-1:0]  flush_o;
    logic               if_rsp_drop_o;
    logic [CNT_W-1:0]   stall_cycles_o;
    logic               timeout_o;
    logic               err_o;

    modport master (
        output req_valid_i, if_req_fire_i, if_rsp_valid_i,
        input  stall_o, flush_o, if_rsp_drop_o, stall_cycles_o, timeout_o, err_o
    );

    modport slave (
        input  req_valid_i, if_req_fire_i, if_rsp_valid_i,
        output stall_o, flush_o, if_rsp_drop_o, stall_cycles_o, timeout_o, err_o
    );
endinterface

// File: rtl/pipe_prio_enc.sv
// pipe_prio_enc
// Highest-index-wins priority encoder.
//   req   : request vector
//   idx   : index of the highest set bit (0 when none)
//   valid : at least one request bit set
module pipe_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan upward so the last (highest) set bit overwrites any lower one.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central pipeline hazard controller. Picks the highest-priority hazard source
// each cycle and drives per-stage stall/flush from its table entry. Tracks
// in-flight fetches so that, after a PC redirect, responses to wrong-path
// fetches are flagged for discard (DRAIN state). Also keeps a stall-cycle
// performance counter, a stall watchdog and a fetch-protocol error flag.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : pipe_hazard_ctrl_if slave (requests in, control/status out)
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                          STAGES        = 6,
    parameter int                          NUM_REQ       = 8,
    parameter logic [NUM_REQ*STAGES-1:0]   STALL_MASK    = DEF_STALL_MASK,
    parameter logic [NUM_REQ*STAGES-1:0]   FLUSH_MASK    = DEF_FLUSH_MASK,
    parameter logic [NUM_REQ-1:0]          REDIRECT_MASK = 8'b0011_0100,
    parameter logic [STAGES-1:0]           DRAIN_FLUSH   = 6'b000010,
    parameter int                          OUTST_MAX     = 3,
    parameter int                          TIMEOUT       = 1024,
    parameter int                          CNT_W         = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int OUTST_W = $clog2(OUTST_MAX + 1);
    localparam int RUN_W   = $clog2(TIMEOUT + 1);

    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic               redirect;
    logic [STAGES-1:0]  stall_raw;
    logic [STAGES-1:0]  flush_raw;
    logic [STAGES-1:0]  stall;
    logic [STAGES-1:0]  flush;
    logic               drop;

    state_e             state;
    state_e             state_next;
    logic [OUTST_W-1:0] outst;
    logic [OUTST_W-1:0] outst_next;
    logic [OUTST_W-1:0] drop_cnt;
    logic [OUTST_W-1:0] drop_next;
    logic               err_set;
    logic [RUN_W-1:0]   run_cnt;
    logic [CNT_W-1:0]   stall_cycles;
    logic               timeout;
    logic               err;

    pipe_prio_enc #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req   (bus.req_valid_i),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Table lookup for the winning source. Flush beats stall on the same
    // stage: a stage being emptied must not also hold its old contents.
    always_comb begin
        stall_raw = '0;
        flush_raw = '0;
        if (win_valid) begin
            stall_raw = STAGES'(mask_slice(MASK_MAX_W'(STALL_MASK), 32'(win_idx), STAGES));
            flush_raw = STAGES'(mask_slice(MASK_MAX_W'(FLUSH_MASK), 32'(win_idx), STAGES));
        end
        if (state == ST_DRAIN) begin
            flush_raw = flush_raw | DRAIN_FLUSH;
        end
        redirect = win_valid & REDIRECT_MASK[win_idx];
    end

    // Outstanding-fetch bookkeeping. Illegal traffic (response with nothing
    // in flight, fetch beyond capacity) leaves the count alone and raises err.
    always_comb begin
        outst_next = outst;
        err_set    = 1'b0;
        if (bus.if_rsp_valid_i && outst == '0) begin
            err_set = 1'b1;
        end else if (bus.if_req_fire_i && !bus.if_rsp_valid_i) begin
            if (outst == OUTST_W'(OUTST_MAX)) begin
                err_set = 1'b1;
            end else begin
                outst_next = outst + 1'b1;
            end
        end else if (bus.if_rsp_valid_i && !bus.if_req_fire_i) begin
            outst_next = outst - 1'b1;
        end
    end

    // Stale-response tracking. A redirect makes every fetch still in flight
    // after this cycle (including one fired now) stale, replacing any older
    // drain count. Responses return in order, so the next drop_cnt responses
    // are exactly the stale ones.
    always_comb begin
        drop       = 1'b0;
        drop_next  = drop_cnt;
        state_next = state;
        if (redirect) begin
            drop       = bus.if_rsp_valid_i;
            drop_next  = outst_next;
            state_next = (outst_next != '0) ? ST_DRAIN : ST_RUN;
        end else if (state == ST_DRAIN) begin
            drop = bus.if_rsp_valid_i;
            if (bus.if_rsp_valid_i) begin
                drop_next = drop_cnt - 1'b1;
            end
            state_next = (drop_next != '0) ? ST_DRAIN : ST_RUN;
        end
    end

    // Reset forces a full flush and no stall so the pipeline comes up empty.
    always_comb begin
        if (rst) begin
            stall = '0;
            flush = '1;
        end else begin
            stall = stall_raw & ~flush_raw;
            flush = flush_raw;
        end
    end

    assign bus.stall_o        = stall;
    assign bus.flush_o        = flush;
    assign bus.if_rsp_drop_o  = drop & ~rst;
    assign bus.stall_cycles_o = stall_cycles;
    assign bus.timeout_o      = timeout;
    assign bus.err_o          = err;

    // State, counters and sticky flags. run_cnt saturates at TIMEOUT so it
    // cannot wrap and re-arm while a stall persists.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            outst        <= '0;
            drop_cnt     <= '0;
            run_cnt      <= '0;
            stall_cycles <= '0;
            timeout      <= 1'b0;
            err          <= 1'b0;
        end else begin
            state    <= state_next;
            outst    <= outst_next;
            drop_cnt <= drop_next;
            if (err_set) begin
                err <= 1'b1;
            end
            if (stall[STG_PC] && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (stall != '0) begin
                if (run_cnt != RUN_W'(TIMEOUT)) begin
                    run_cnt <= run_cnt + 1'b1;
                end
                if (run_cnt == RUN_W'(TIMEOUT - 1)) begin
                    timeout <= 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Scoreboard bench for pipe_hazard_ctrl. The driver applies one cycle of
// stimulus, asks the reference model for the expected response and queues it;
// the monitor pops one expectation per cycle and compares on the falling edge.
// The model tracks fetches as an ordered list of in-flight entries, each
// tagged stale or not, rather than as counters.
module tb_pipe_hazard_ctrl;

    localparam int NUM_REQ   = 8;
    localparam int STAGES    = 6;
    localparam int CNT_W     = 4;
    localparam int TIMEOUT   = 4;
    localparam int OUTST_MAX = 3;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;

    typedef struct {
        logic [5:0] stall;
        logic [5:0] flush;
        logic       drop;
        logic       err;
        logic       timeout;
        logic [3:0] cyc;
        int         cycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int passes = 0;
    int cycle_no = 0;

    exp_t sb[$];

    // Reference model state
    bit   inflight[$];
    int   m_stallcyc = 0;
    int   m_run = 0;
    bit   m_timeout = 1'b0;
    bit   m_err = 1'b0;

    // Intent of each hazard source, indexed by source number
    logic [5:0] stall_tab [8] = '{6'b000111, 6'b001111, 6'b000000, 6'b000011,
                                  6'b000000, 6'b000000, 6'b011111, 6'b000000};
    logic [5:0] flush_tab [8] = '{6'b001000, 6'b010000, 6'b000110, 6'b000100,
                                  6'b001110, 6'b011110, 6'b100000, 6'b000000};
    bit         redir_src [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(
        .NUM_REQ (NUM_REQ),
        .STAGES  (STAGES),
        .CNT_W   (CNT_W)
    ) bus ();

    pipe_hazard_ctrl #(
        .OUTST_MAX (OUTST_MAX),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One comparison; prints a FAIL line on mismatch.
    task automatic checkOutput(input string name, input int cyc,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Drive one cycle of inputs, predict the response and queue it.
    task automatic applyStimulus(input bit r, input logic [7:0] req,
                                 input bit fire, input bit rsp);
        exp_t e;
        int   win;
        bit   draining;
        bit   popped;
        logic [5:0] fl;
        logic [5:0] st;
        bit   redir;

        @(posedge clk);
        #1;
        rst                = r;
        bus.req_valid_i    = req;
        bus.if_req_fire_i  = fire;
        bus.if_rsp_valid_i = rsp;
        cycle_no++;

        e.cycle   = cycle_no;
        e.err     = m_err;
        e.timeout = m_timeout;
        e.cyc     = 4'(m_stallcyc);

        if (r) begin
            e.stall = '0;
            e.flush = '1;
            e.drop  = 1'b0;
            inflight.delete();
            m_stallcyc = 0;
            m_run      = 0;
            m_timeout  = 1'b0;
            m_err      = 1'b0;
        end else begin
            win = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) win = i;
            end
            draining = 1'b0;
            foreach (inflight[k]) begin
                if (inflight[k]) draining = 1'b1;
            end
            fl    = ((win >= 0) ? flush_tab[win] : 6'b0) | (draining ? 6'b000010 : 6'b0);
            st    = ((win >= 0) ? stall_tab[win] : 6'b0) & ~fl;
            redir = (win >= 0) && redir_src[win];

            popped = 1'b0;
            if (rsp && inflight.size() == 0) begin
                m_err = 1'b1;
            end else if (fire && !rsp && inflight.size() == OUTST_MAX) begin
                m_err = 1'b1;
            end else begin
                if (rsp) popped = inflight.pop_front();
                if (fire) inflight.push_back(1'b0);
            end
            if (redir) begin
                foreach (inflight[k]) inflight[k] = 1'b1;
            end

            e.stall = st;
            e.flush = fl;
            e.drop  = rsp && (redir || popped);

            if (st[0] && m_stallcyc < CNT_SAT) m_stallcyc++;
            if (st != 6'b0) begin
                if (m_run < TIMEOUT) m_run++;
                if (m_run == TIMEOUT) m_timeout = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("stall_o",        e.cycle, 32'(bus.stall_o),        32'(e.stall));
            checkOutput("flush_o",        e.cycle, 32'(bus.flush_o),        32'(e.flush));
            checkOutput("if_rsp_drop_o",  e.cycle, 32'(bus.if_rsp_drop_o),  32'(e.drop));
            checkOutput("err_o",          e.cycle, 32'(bus.err_o),          32'(e.err));
            checkOutput("timeout_o",      e.cycle, 32'(bus.timeout_o),      32'(e.timeout));
            checkOutput("stall_cycles_o", e.cycle, 32'(bus.stall_cycles_o), 32'(e.cyc));
        end
    end

    initial begin
        logic [7:0] rq;
        bit         rs;

        bus.req_valid_i    = '0;
        bus.if_req_fire_i  = 1'b0;
        bus.if_rsp_valid_i = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then a two-source request resolved to source 3
        applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(0, 8'b0000_1001, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);

        // Two fetches, redirect, two stale responses, then a live one
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'b0000_0100, 0, 0);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'b0000_0001, 0, 1);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 1);

        // Redirect coincident with fire and response at one outstanding
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'b0001_0000, 1, 1);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 0);

        // Second redirect while draining reloads the drop count
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'b0010_0000, 0, 0);
        applyStimulus(0, 8'b0000_0100, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 1);

        // Watchdog: four stalled cycles set it, it sticks, reset clears it
        applyStimulus(1, 8'h00, 0, 0);
        repeat (4) applyStimulus(0, 8'b0000_0001, 0, 0);
        repeat (2) applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);

        // Fetch beyond capacity, then reset in the middle of a drain
        repeat (3) applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'b0000_0100, 0, 0);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 1);

        // Stall-cycle counter saturation
        applyStimulus(1, 8'h00, 0, 0);
        repeat (20) applyStimulus(0, 8'b0000_0010, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            rq = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255) & $urandom_range(0, 255)) : 8'h00;
            if (inflight.size() == 0) rs = ($urandom_range(0, 15) == 0);
            else rs = ($urandom_range(0, 1) == 1);
            applyStimulus(($urandom_range(0, 63) == 0), rq, ($urandom_range(0, 1) == 1), rs);
        end

        @(posedge clk);
        #1;
        bus.req_valid_i    = '0;
        bus.if_req_fire_i  = 1'b0;
        bus.if_rsp_valid_i = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain_scoreboard: %0d expectations left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
